// File: rtl/dp_pkg.sv
// Shared Q8.8 constants, product slice bounds and sequencer state encoding
// for the dot-product datapath.
package dp_pkg;

  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PROD_W    = 32;
  localparam int unsigned PROD_LO   = FRAC_BITS;
  localparam int unsigned PROD_HI   = FRAC_BITS + DATA_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Optional ReLU on a signed Q8.8 value.
  function automatic logic [DATA_W-1:0] relu_q88(input logic [DATA_W-1:0] x,
                                                 input logic en);
    return (en && x[DATA_W-1]) ? '0 : x;
  endfunction

endpackage

// File: rtl/mac_q88_core.sv
// Q8.8 multiply-accumulate: 16x16 signed product, truncated to [23:8], added
// with 16-bit wrap into a registered result. A bias load seeds the result.
module mac_q88_core
  import dp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              bias_load,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] pix,
  input  logic [DATA_W-1:0] wgt,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] sum_c
);

  logic signed [PROD_W-1:0] prod;
  logic                     unused_prod_bits;

  assign prod  = PROD_W'($signed(pix)) * PROD_W'($signed(wgt));
  assign sum_c = result + prod[PROD_HI:PROD_LO];

  // Bits outside the Q8.8 window are intentionally discarded.
  assign unused_prod_bits = ^{prod[PROD_W-1:PROD_HI+1], prod[PROD_LO-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (bias_load) begin
      result <= bias;
    end else if (load_en) begin
      result <= sum_c;
    end
  end

endmodule

// File: rtl/dot_product_seq.sv
// Sequencer that streams pixel/weight pairs from two sync-read memories into
// the Q8.8 MAC and returns the (optionally ReLU'd) dot product on valid/ready.
module dot_product_seq
  import dp_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter bit          RELU   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] pix_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [15:0]       bias,
  output logic              busy,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [15:0]       pix_rdata,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_addr,
  input  logic [15:0]       wgt_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data
);

  state_t              state;
  logic [ADDR_W-1:0]   remain;
  logic                data_valid;
  logic                bias_load_c;
  logic [DATA_W-1:0]   mac_result;
  logic [DATA_W-1:0]   mac_sum_c;

  // The bias seeds the accumulator at command accept, so element 0 adds to it.
  assign bias_load_c = (state == ST_IDLE) && start;

  mac_q88_core u_mac (
    .clk       (clk),
    .reset     (reset),
    .load_en   (data_valid),
    .bias_load (bias_load_c),
    .bias      (bias),
    .pix       (pix_rdata),
    .wgt       (wgt_rdata),
    .result    (mac_result),
    .sum_c     (mac_sum_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      pix_rd_en  <= 1'b0;
      wgt_rd_en  <= 1'b0;
      pix_addr   <= '0;
      wgt_addr   <= '0;
      remain     <= '0;
      data_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      // Read data returns one cycle after each issued read.
      data_valid <= pix_rd_en;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state     <= ST_FETCH;
              pix_rd_en <= 1'b1;
              wgt_rd_en <= 1'b1;
              pix_addr  <= pix_base;
              wgt_addr  <= wgt_base;
              remain    <= len - ADDR_W'(1);
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_data  <= relu_q88(bias, RELU);
            end
          end
        end
        ST_FETCH: begin
          if (remain == '0) begin
            state     <= ST_DRAIN;
            pix_rd_en <= 1'b0;
            wgt_rd_en <= 1'b0;
          end else begin
            pix_addr <= pix_addr + ADDR_W'(1);
            wgt_addr <= wgt_addr + ADDR_W'(1);
            remain   <= remain - ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // Last pair is being accumulated now; capture its sum directly.
          state     <= ST_DONE;
          out_valid <= 1'b1;
          out_data  <= relu_q88(mac_sum_c, RELU);
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_result;
  assign unused_result = ^mac_result;

endmodule

// File: tb/tb_dot_product_seq.sv
// Randomized and directed checks of dot_product_seq (RELU=0 and RELU=1
// instances) against an arithmetic reference model of the dot product.
module tb_dot_product_seq;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [7:0]  len, pix_base, wgt_base;
  logic [15:0] bias;

  logic        busy0, pix_rd_en0, wgt_rd_en0, out_valid0;
  logic [7:0]  pix_addr0, wgt_addr0;
  logic [15:0] pix_rdata0, wgt_rdata0, out_data0;
  logic        busy1, pix_rd_en1, wgt_rd_en1, out_valid1;
  logic [7:0]  pix_addr1, wgt_addr1;
  logic [15:0] pix_rdata1, wgt_rdata1, out_data1;

  logic [15:0] pmem [256];
  logic [15:0] wmem [256];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] last0, last1;

  always #5 clk = ~clk;

  dot_product_seq #(.ADDR_W(8), .RELU(1'b0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .pix_base(pix_base), .wgt_base(wgt_base), .bias(bias), .busy(busy0),
    .pix_rd_en(pix_rd_en0), .pix_addr(pix_addr0), .pix_rdata(pix_rdata0),
    .wgt_rd_en(wgt_rd_en0), .wgt_addr(wgt_addr0), .wgt_rdata(wgt_rdata0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
  );

  dot_product_seq #(.ADDR_W(8), .RELU(1'b1)) u_dut_relu (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .pix_base(pix_base), .wgt_base(wgt_base), .bias(bias), .busy(busy1),
    .pix_rd_en(pix_rd_en1), .pix_addr(pix_addr1), .pix_rdata(pix_rdata1),
    .wgt_rd_en(wgt_rd_en1), .wgt_addr(wgt_addr1), .wgt_rdata(wgt_rdata1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
  );

  // Synchronous-read memories, one read port per instance.
  always @(posedge clk) begin
    if (pix_rd_en0) pix_rdata0 <= pmem[pix_addr0];
    if (wgt_rd_en0) wgt_rdata0 <= wmem[wgt_addr0];
    if (pix_rd_en1) pix_rdata1 <= pmem[pix_addr1];
    if (wgt_rd_en1) wgt_rdata1 <= wmem[wgt_addr1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Dot product with per-term truncation to Q8.8 and 16-bit wrap.
  function automatic logic [15:0] model(input int n, input logic [7:0] pb,
                                        input logic [7:0] wb, input logic [15:0] b);
    int acc;
    int p;
    acc = int'($signed(b));
    for (int i = 0; i < n; i++) begin
      p   = int'($signed(pmem[8'(pb + i)])) * int'($signed(wmem[8'(wb + i)]));
      acc = acc + (p >>> 8);
    end
    return 16'(acc);
  endfunction

  function automatic logic [15:0] relu_ref(input logic [15:0] x);
    return x[15] ? 16'h0000 : x;
  endfunction

  task automatic run_job(input int n, input logic [7:0] pb, input logic [7:0] wb,
                         input logic [15:0] b, input int hold);
    logic [15:0] exp;
    int          cyc;
    exp      = model(n, pb, wb, b);
    start    = 1'b1;
    len      = 8'(n);
    pix_base = pb;
    wgt_base = wb;
    bias     = b;
    tick;
    start = 1'b0;
    cyc   = 1;
    while (!out_valid0 && cyc <= n + 4) begin
      check("busy_run", 32'(busy0), 32'd1);
      check("pix_rd_en", 32'(pix_rd_en0), 32'(cyc <= n));
      check("wgt_rd_en", 32'(wgt_rd_en0), 32'(cyc <= n));
      if (cyc <= n) begin
        check("pix_addr", 32'(pix_addr0), 32'(8'(pb + cyc - 1)));
        check("wgt_addr", 32'(wgt_addr0), 32'(8'(wb + cyc - 1)));
        check("pix_addr_relu", 32'(pix_addr1), 32'(8'(pb + cyc - 1)));
      end
      tick;
      cyc++;
    end
    check("latency", 32'(cyc), (n == 0) ? 32'd1 : 32'(n + 2));
    check("out_valid", 32'(out_valid0), 32'd1);
    check("out_valid_relu", 32'(out_valid1), 32'd1);
    check("rd_at_done", 32'(pix_rd_en0 | wgt_rd_en0), 32'd0);
    check("out_data", 32'(out_data0), 32'(exp));
    check("out_data_relu", 32'(out_data1), 32'(relu_ref(exp)));
    last0 = out_data0;
    last1 = out_data1;
    // Backpressure with start pulses that must be ignored.
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len   = 8'($urandom_range(0, 5));
      tick;
      check("bp_valid", 32'(out_valid0), 32'd1);
      check("bp_data", 32'(out_data0), 32'(exp));
      check("bp_busy", 32'(busy0), 32'd1);
      check("bp_rd", 32'(pix_rd_en0 | wgt_rd_en0), 32'd0);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick;
    out_ready = 1'b0;
    start     = 1'b0;
    check("hs_valid", 32'(out_valid0), 32'd0);
    check("hs_busy", 32'(busy0), 32'd0);
    check("hs_busy_relu", 32'(busy1), 32'd0);
    check("hs_rd", 32'(pix_rd_en0), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    len = '0; pix_base = '0; wgt_base = '0; bias = '0;
    for (int i = 0; i < 256; i++) begin
      pmem[i] = 16'($urandom);
      wmem[i] = 16'($urandom);
    end
    tick; tick;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_rd", 32'(pix_rd_en0 | wgt_rd_en0), 32'd0);
    check("rst_addr", 32'({pix_addr0, wgt_addr0}), 32'd0);
    check("rst_valid", 32'(out_valid0 | out_valid1), 32'd0);
    check("rst_data", 32'({out_data0, out_data1}), 32'd0);
    reset = 1'b0;
    tick;

    // Basic dot product.
    pmem[8'h10] = 16'h0100; pmem[8'h11] = 16'h0200; pmem[8'h12] = 16'h0180;
    wmem[8'h20] = 16'h0200; wmem[8'h21] = 16'h0080; wmem[8'h22] = 16'h0200;
    run_job(3, 8'h10, 8'h20, 16'h0040, 0);
    check("basic", 32'(last0), 32'h0640);
    check("basic_relu", 32'(last1), 32'h0640);

    // Negative result.
    pmem[8'h30] = 16'hFF00; wmem[8'h31] = 16'h0300;
    run_job(1, 8'h30, 8'h31, 16'h0000, 2);
    check("neg", 32'(last0), 32'hFD00);
    check("neg_relu", 32'(last1), 32'h0000);

    // Long backpressure.
    run_job(2, 8'h40, 8'h50, 16'h0100, 10);

    // Zero length.
    run_job(0, 8'h00, 8'h00, 16'h1234, 1);
    check("zero_len", 32'(last0), 32'h1234);

    // Address wrap.
    pmem[8'hFF] = 16'h0100; pmem[8'h00] = 16'h0100; pmem[8'h01] = 16'h0100;
    wmem[8'hFE] = 16'h0100; wmem[8'hFF] = 16'h0200; wmem[8'h00] = 16'h0300;
    run_job(3, 8'hFF, 8'hFE, 16'h0000, 0);
    check("wrap", 32'(last0), 32'h0600);

    // Truncation and wrap of the product slice.
    pmem[8'h80] = 16'h7FFF; wmem[8'h81] = 16'h7FFF;
    run_job(1, 8'h80, 8'h81, 16'h0000, 0);
    check("trunc", 32'(last0), 32'hFF00);
    check("trunc_relu", 32'(last1), 32'h0000);

    // Reset in cycle 3 of a len=8 run.
    start = 1'b1; len = 8'd8; pix_base = 8'h90; wgt_base = 8'hA0; bias = 16'h7777;
    tick;
    start = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy0 | busy1), 32'd0);
    check("mid_rst_rd", 32'(pix_rd_en0 | wgt_rd_en0), 32'd0);
    check("mid_rst_addr", 32'({pix_addr0, wgt_addr0}), 32'd0);
    check("mid_rst_out", 32'({out_valid0, out_data0}), 32'd0);
    tick;
    check("post_rst_idle", 32'(busy0 | pix_rd_en0 | out_valid0), 32'd0);
    pmem[8'h60] = 16'h0100; wmem[8'h70] = 16'h0100;
    run_job(1, 8'h60, 8'h70, 16'h0000, 0);
    check("recover", 32'(last0), 32'h0100);

    // Random jobs.
    for (int j = 0; j < 25; j++) begin
      run_job(int'($urandom_range(0, 12)), 8'($urandom), 8'($urandom),
              16'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
Initiator-side sequencer for the Q8.8 multiply-accumulate datapath. On a start command it reads LEN pixel/weight pairs from two synchronous-read memories and streams them into an internal MAC core. It feeds the MAC's registered result back as the accumulate operand, seeded with a bias. It then presents the final dot product, with optional ReLU, on a valid/ready output port. It sits between the pixel/weight buffers and the layer-output writer.

Parameters:
ADDR_W, 8, width of memory addresses and of the len input
RELU, 0, 1 = clamp negative final result to 0x0000; 0 = pass signed result unchanged

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  command strobe; sampled only in IDLE
len  in  ADDR_W  number of pixel/weight pairs (0 allowed)
pix_base  in  ADDR_W  first pixel address
wgt_base  in  ADDR_W  first weight address
bias  in  16  signed Q8.8 initial accumulator value
busy  out  1  high whenever state != IDLE
pix_rd_en  out  1  pixel memory read enable
pix_addr  out  ADDR_W  pixel read address
pix_rdata  in  16  signed Q8.8 pixel; valid the cycle after pix_rd_en
wgt_rd_en  out  1  weight memory read enable
wgt_addr  out  ADDR_W  weight read address
wgt_rdata  in  16  signed Q8.8 weight; valid the cycle after wgt_rd_en
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  16  signed Q8.8 dot product

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state to IDLE.
  - busy, pix_rd_en, wgt_rd_en, out_valid all 0.
  - pix_addr, wgt_addr, out_data all 0.
  - MAC result register to 0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 with len>0: latch inputs, go to FETCH.
  - start=1 with len=0: load result register with bias, go to DONE.
  - start=0: stay in IDLE.
- FETCH:
  - Lasts len cycles; issue index i = 0..len-1, one per cycle.
  - pix_rd_en = wgt_rd_en = 1.
  - pix_addr = (pix_base + i) mod 2^ADDR_W; wgt_addr = (wgt_base + i) mod 2^ADDR_W. Addresses are registered outputs.
  - After the last index, go to DRAIN.
- DRAIN:
  - One cycle; rd_en = 0.
  - The last returned pair enters the MAC this cycle; then go to DONE.
- MAC data:
  - In the cycle after each read, the MAC operands are pixel = pix_rdata and weight = wgt_rdata.
  - accum = bias for element 0; for every later element, accum = the registered MAC result.
- MAC arithmetic:
  - product = 32-bit signed pixel*weight.
  - sum = accum + product[23:8] (truncating, 16-bit wrap, no saturation).
  - The result register updates on every data-valid cycle, and only then.
- Latency: start high in cycle 0 with len = N>0 gives out_valid rising in cycle N+2.
- len=0: out_valid rises in cycle 1 with out_data = bias (RELU applied).
- DONE:
  - out_valid = 1; out_data = result, or 0x0000 if RELU=1 and result[15]=1.
  - out_data is held stable while out_ready = 0.
  - Handshake cycle (out_valid & out_ready): go to IDLE next cycle, with out_valid and busy falling.
- Start handling:
  - start is ignored in every state other than IDLE, including the handshake cycle.
  - No command queueing.
- Reset mid-operation: return to the reset values above on the next edge. No partial result is emitted, and no further reads are issued.
- busy = 1 from the cycle after start is accepted through the handshake cycle.

Decomposition:
- Shared package (dp_pkg):
  - Q8.8 constants: FRAC_BITS = 8, DATA_W = 16, PROD_W = 32.
  - Product slice indices [23:8].
  - State enum for IDLE/FETCH/DRAIN/DONE.
- One sub-module, mac_q88_core: combinational multiply plus truncate-add into a registered 16-bit result, with a load-enable and a bias-load path.
- The sequencer FSM, address counters, data-valid pipeline flag, and output stage stay in dot_product_seq.

Test Plan:
- Basic dot product:
  - Stimulus: len=3, pixels {0x0100,0x0200,0x0180}, weights {0x0200,0x0080,0x0200}, bias 0x0040, out_ready=1.
  - Response: out_valid in cycle 5, out_data 0x0640 (2+1+3+0.25); rd_en high in cycles 1-3 only.
- Negative result:
  - Stimulus: len=1, pixel 0xFF00 (-1), weight 0x0300 (3), bias 0.
  - Response: RELU=0 gives out_data 0xFD00 in cycle 3; RELU=1 gives 0x0000.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid, pulsing start throughout.
  - Response: out_data stable, busy=1, no rd_en, no new command; out_ready=1 gives a handshake and busy=0 next cycle.
- Zero length:
  - Stimulus: len=0, bias 0x1234.
  - Response: out_valid in cycle 1 with out_data 0x1234, and no memory reads.
- Address wrap with ADDR_W=8:
  - Stimulus: pix_base=0xFF, wgt_base=0xFE, len=3.
  - Response: pix_addr 0xFF,0x00,0x01 and wgt_addr 0xFE,0xFF,0x00.
- Truncation: pixel=weight=0x7FFF, bias 0 gives out_data = product[23:8] = 0xFF00 (wrap, not saturate).
- Reset recovery:
  - Stimulus: assert reset in cycle 3 of a len=8 run.
  - Response: next cycle all outputs 0 and state IDLE; a following len=1 job (0x0100 × 0x0100, bias 0) returns 0x0100, with no residue from the aborted run.
